// File: rtl/codec_map_dec_input_buffer_if.sv
// ----------------------------------------------------------------------------
// codec_map_dec_input_buffer_if
//   Bundles the writer stream, the frame ownership handshake and the two read
//   ports of the MAP decoder input buffer.
//
//   Handshake semantics (the only place they are written down):
//     - Write stream: a symbol is transferred on a cycle where ival=1 and
//       ordy=1. isop/ieop are qualified by ival. ival while ordy=0 is dropped.
//     - Frame hand-off: obuf_rdy=1 means a complete frame of obuf_len words is
//       owned by the decoder. A one-cycle irelease while obuf_rdy=1 returns
//       it; irelease while obuf_rdy=0 has no effect.
//     - Reads: iread launches a read of iraddr0/iraddr1 (opposite LSBs);
//       orval marks the matching ordat0/ordat1 after the read latency.
//
//   Modports:
//     master : upstream writer + decoder (drive i*, observe o*)
//     slave  : the buffer itself
// ----------------------------------------------------------------------------
interface codec_map_dec_input_buffer_if #(
    parameter int pDAT_W  = 8,
    parameter int pADDR_W = 8
);
    logic               ival;
    logic               isop;
    logic               ieop;
    logic [pDAT_W-1:0]  idat;
    logic               ordy;
    logic               obuf_rdy;
    logic [pADDR_W:0]   obuf_len;
    logic               irelease;
    logic               iread;
    logic [pADDR_W-1:0] iraddr0;
    logic [pADDR_W-1:0] iraddr1;
    logic               orval;
    logic [pDAT_W-1:0]  ordat0;
    logic [pDAT_W-1:0]  ordat1;

    modport master (
        output ival, isop, ieop, idat, irelease, iread, iraddr0, iraddr1,
        input  ordy, obuf_rdy, obuf_len, orval, ordat0, ordat1
    );

    modport slave (
        input  ival, isop, ieop, idat, irelease, iread, iraddr0, iraddr1,
        output ordy, obuf_rdy, obuf_len, orval, ordat0, ordat1
    );
endinterface

// File: rtl/codec_map_dec_input_buffer.sv
// ----------------------------------------------------------------------------
// codec_map_dec_input_buffer
//   Ping-pong frame buffer in front of the MAP decoder. Frames arrive one
//   symbol per cycle and are stored split into even/odd address banks so the
//   decoder can read one even and one odd address per cycle.
//
//   Ports:
//     iclk         : clock
//     ireset       : synchronous active-high reset
//     iclkena      : clock enable, all state holds while low
//     bus          : slave side of codec_map_dec_input_buffer_if
//     dbg_wr_state : write FSM state (0 = idle, 1 = inside a frame)
// ----------------------------------------------------------------------------
module codec_map_dec_input_buffer #(
    parameter int pDAT_W  = 8,
    parameter int pADDR_W = 8,
    parameter int pRPIPE  = 0
) (
    input  logic iclk,
    input  logic ireset,
    input  logic iclkena,
    codec_map_dec_input_buffer_if.slave bus,
    output logic dbg_wr_state
);
    localparam int BANK_D = 2 ** (pADDR_W - 1);
    localparam logic [pADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [pADDR_W-1:0] ONE_A     = 1;
    localparam logic [pADDR_W:0]   ONE_L     = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_t;

    wr_state_t          state;
    logic [pADDR_W-1:0] wcnt;
    logic               wbuf;
    logic               rbuf;
    logic [1:0]         full;
    logic [pADDR_W:0]   len [2];
    logic               ordy_r;

    // Buffer number is the MSB of the bank index.
    logic [pDAT_W-1:0] ram_even [2*BANK_D];
    logic [pDAT_W-1:0] ram_odd  [2*BANK_D];

    logic               wr_en;
    logic               wr_close;
    logic               rel;
    logic [pADDR_W-1:0] waddr;
    logic [1:0]         full_nxt;
    logic               wbuf_nxt;
    logic               rbuf_nxt;

    always_comb begin
        // Outside a frame only a sop is accepted; a sop inside a frame
        // restarts it at address 0 of the same buffer.
        wr_en    = bus.ival & ordy_r & (bus.isop | (state == ST_WRITE));
        waddr    = bus.isop ? '0 : wcnt;
        wr_close = wr_en & (bus.ieop | (waddr == LAST_ADDR));
        rel      = bus.irelease & full[rbuf];
        // Close and release always address different buffers, so both
        // updates can be applied to the same next-state vector.
        full_nxt = full;
        if (rel)
            full_nxt[rbuf] = 1'b0;
        if (wr_close)
            full_nxt[wbuf] = 1'b1;
        wbuf_nxt = wbuf ^ wr_close;
        rbuf_nxt = rbuf ^ rel;
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state  <= ST_IDLE;
            wcnt   <= '0;
            wbuf   <= 1'b0;
            rbuf   <= 1'b0;
            full   <= '0;
            len[0] <= '0;
            len[1] <= '0;
            ordy_r <= 1'b1;
        end else if (iclkena) begin
            full   <= full_nxt;
            wbuf   <= wbuf_nxt;
            rbuf   <= rbuf_nxt;
            ordy_r <= ~full_nxt[wbuf_nxt];
            if (wr_en) begin
                if (wr_close) begin
                    len[wbuf] <= {1'b0, waddr} + ONE_L;
                    state     <= ST_IDLE;
                    wcnt      <= '0;
                end else begin
                    state <= ST_WRITE;
                    wcnt  <= waddr + ONE_A;
                end
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (iclkena && wr_en) begin
            if (waddr[0])
                ram_odd[{wbuf, waddr[pADDR_W-1:1]}] <= bus.idat;
            else
                ram_even[{wbuf, waddr[pADDR_W-1:1]}] <= bus.idat;
        end
    end

    // Read side: port 0 chooses which bank it uses; port 1 gets the other.
    logic               rsel;
    logic [pADDR_W-2:0] ra_even;
    logic [pADDR_W-2:0] ra_odd;

    always_comb begin
        rsel    = bus.iraddr0[0];
        ra_even = rsel ? bus.iraddr1[pADDR_W-1:1] : bus.iraddr0[pADDR_W-1:1];
        ra_odd  = rsel ? bus.iraddr0[pADDR_W-1:1] : bus.iraddr1[pADDR_W-1:1];
    end

    logic              rval1;
    logic              rsel1;
    logic [pDAT_W-1:0] rd_even;
    logic [pDAT_W-1:0] rd_odd;
    logic [pDAT_W-1:0] dat0_1;
    logic [pDAT_W-1:0] dat1_1;

    always_ff @(posedge iclk) begin
        if (ireset) begin
            rval1   <= 1'b0;
            rsel1   <= 1'b0;
            rd_even <= '0;
            rd_odd  <= '0;
        end else if (iclkena) begin
            rval1 <= bus.iread;
            if (bus.iread) begin
                rd_even <= ram_even[{rbuf, ra_even}];
                rd_odd  <= ram_odd[{rbuf, ra_odd}];
                rsel1   <= rsel;
            end
        end
    end

    // Swap the banks back so ordat0 always belongs to iraddr0.
    always_comb begin
        dat0_1 = rsel1 ? rd_odd  : rd_even;
        dat1_1 = rsel1 ? rd_even : rd_odd;
    end

    generate
        if (pRPIPE != 0) begin : g_rpipe
            logic              rval2;
            logic [pDAT_W-1:0] dat0_2;
            logic [pDAT_W-1:0] dat1_2;

            always_ff @(posedge iclk) begin
                if (ireset) begin
                    rval2  <= 1'b0;
                    dat0_2 <= '0;
                    dat1_2 <= '0;
                end else if (iclkena) begin
                    rval2  <= rval1;
                    dat0_2 <= dat0_1;
                    dat1_2 <= dat1_1;
                end
            end

            assign bus.orval  = rval2;
            assign bus.ordat0 = dat0_2;
            assign bus.ordat1 = dat1_2;
        end else begin : g_rdirect
            assign bus.orval  = rval1;
            assign bus.ordat0 = dat0_1;
            assign bus.ordat1 = dat1_1;
        end
    endgenerate

    assign bus.ordy     = ordy_r;
    assign bus.obuf_rdy = full[rbuf];
    assign bus.obuf_len = len[rbuf];
    assign dbg_wr_state = state;
endmodule

// File: tb/tb_codec_map_dec_input_buffer.sv
// ----------------------------------------------------------------------------
// tb_codec_map_dec_input_buffer
//   Two instances (read latency 1 and 2) share one stimulus stream. A frame
//   level model (queue of complete frames plus the frame being assembled)
//   predicts ordy/obuf_rdy/obuf_len and read data every cycle.
// ----------------------------------------------------------------------------
module tb_codec_map_dec_input_buffer;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NW = 16;

    logic clk;
    logic ireset;
    logic iclkena;
    logic ival, isop, ieop, irelease, iread;
    logic [DW-1:0] idat;
    logic [AW-1:0] iraddr0, iraddr1;
    logic dbg_a, dbg_b;

    codec_map_dec_input_buffer_if #(.pDAT_W(DW), .pADDR_W(AW)) ifa ();
    codec_map_dec_input_buffer_if #(.pDAT_W(DW), .pADDR_W(AW)) ifb ();

    assign ifa.ival = ival;      assign ifb.ival = ival;
    assign ifa.isop = isop;      assign ifb.isop = isop;
    assign ifa.ieop = ieop;      assign ifb.ieop = ieop;
    assign ifa.idat = idat;      assign ifb.idat = idat;
    assign ifa.irelease = irelease; assign ifb.irelease = irelease;
    assign ifa.iread = iread;    assign ifb.iread = iread;
    assign ifa.iraddr0 = iraddr0; assign ifb.iraddr0 = iraddr0;
    assign ifa.iraddr1 = iraddr1; assign ifb.iraddr1 = iraddr1;

    codec_map_dec_input_buffer #(.pDAT_W(DW), .pADDR_W(AW), .pRPIPE(0)) dut_a (
        .iclk(clk), .ireset(ireset), .iclkena(iclkena), .bus(ifa), .dbg_wr_state(dbg_a)
    );
    codec_map_dec_input_buffer #(.pDAT_W(DW), .pADDR_W(AW), .pRPIPE(1)) dut_b (
        .iclk(clk), .ireset(ireset), .iclkena(iclkena), .bus(ifb), .dbg_wr_state(dbg_b)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- counters / check ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct {
        int            len;
        logic [DW-1:0] d [NW];
    } frame_t;

    frame_t fq[$];
    frame_t cur;
    bit     in_frame = 0;
    int     cur_cnt  = 0;
    bit     m_ordy   = 1;
    bit     started  = 0;
    bit     pv [2] = '{0, 0};
    bit     pk [2] = '{0, 0};
    logic [DW-1:0] p0 [2];
    logic [DW-1:0] p1 [2];
    bit     rel_ok, rd_known, close_now;
    logic [DW-1:0] e0, e1;

    always @(posedge clk) begin
        if (ireset) begin
            fq.delete();
            in_frame = 0;
            cur_cnt  = 0;
            m_ordy   = 1;
            pv = '{0, 0};
            pk = '{0, 0};
            started = 1;
        end else if (iclkena) begin
            // Reads see the frame owned by the decoder before this edge.
            rd_known = fq.size() > 0;
            e0 = '0;
            e1 = '0;
            if (rd_known) begin
                e0 = fq[0].d[iraddr0];
                e1 = fq[0].d[iraddr1];
            end
            pv[1] = pv[0]; pk[1] = pk[0]; p0[1] = p0[0]; p1[1] = p1[0];
            pv[0] = iread; pk[0] = iread && rd_known; p0[0] = e0; p1[0] = e1;

            rel_ok    = irelease && fq.size() > 0;
            close_now = 0;
            if (ival && m_ordy) begin
                if (isop) begin
                    in_frame = 1;
                    cur_cnt  = 0;
                end
                if (in_frame) begin
                    cur.d[cur_cnt] = idat;
                    cur_cnt++;
                    if (ieop || cur_cnt == NW) begin
                        cur.len   = cur_cnt;
                        close_now = 1;
                        in_frame  = 0;
                    end
                end
            end
            if (rel_ok) void'(fq.pop_front());
            if (close_now) fq.push_back(cur);
            m_ordy = fq.size() < 2;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (started) begin
            check("ordy_a", 32'(ifa.ordy), 32'(m_ordy));
            check("ordy_b", 32'(ifb.ordy), 32'(m_ordy));
            check("obuf_rdy", 32'(ifa.obuf_rdy), 32'(fq.size() > 0));
            if (fq.size() > 0)
                check("obuf_len", 32'(ifa.obuf_len), 32'(fq[0].len));
            check("orval_a", 32'(ifa.orval), 32'(pv[0]));
            check("orval_b", 32'(ifb.orval), 32'(pv[1]));
            if (pv[0] && pk[0]) begin
                check("ordat0_a", 32'(ifa.ordat0), 32'(p0[0]));
                check("ordat1_a", 32'(ifa.ordat1), 32'(p1[0]));
            end
            if (pv[1] && pk[1]) begin
                check("ordat0_b", 32'(ifb.ordat0), 32'(p0[1]));
                check("ordat1_b", 32'(ifb.ordat1), 32'(p1[1]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input int n, input bit do_eop);
        for (int i = 0; i < n; i++) begin
            ival = 1'b1;
            isop = (i == 0);
            ieop = do_eop && (i == n - 1);
            idat = base + DW'(i);
            tick();
        end
        ival = 1'b0;
        isop = 1'b0;
        ieop = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        iread   = 1'b1;
        iraddr0 = a0;
        iraddr1 = a1;
        tick();
        iread = 1'b0;
    endtask

    task automatic do_release();
        irelease = 1'b1;
        tick();
        irelease = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        ireset = 1'b1; iclkena = 1'b1;
        ival = 0; isop = 0; ieop = 0; idat = '0;
        irelease = 0; iread = 0; iraddr0 = '0; iraddr1 = '0;
        repeat (3) tick();
        check("rst_ordy", 32'(ifa.ordy), 32'd1);
        check("rst_obuf_rdy", 32'(ifa.obuf_rdy), 32'd0);
        check("rst_obuf_len", 32'(ifa.obuf_len), 32'd0);
        check("rst_orval", 32'(ifa.orval), 32'd0);
        check("rst_ordat0", 32'(ifa.ordat0), 32'd0);
        check("rst_ordat1", 32'(ifa.ordat1), 32'd0);
        ireset = 1'b0;
        tick();

        // Full 16-word frame and swapped-port reads.
        send_frame(8'h10, 16, 1);
        check("f16_rdy", 32'(ifa.obuf_rdy), 32'd1);
        check("f16_len", 32'(ifa.obuf_len), 32'd16);
        do_read(4'd2, 4'd3);
        check("rd23_d0", 32'(ifa.ordat0), 32'h12);
        check("rd23_d1", 32'(ifa.ordat1), 32'h13);
        do_read(4'd5, 4'd4);
        check("rd54_d0", 32'(ifa.ordat0), 32'h15);
        check("rd54_d1", 32'(ifa.ordat1), 32'h14);
        do_release();
        tick();

        // Both buffers full, third frame refused.
        send_frame(8'h20, 10, 1);
        send_frame(8'h40, 10, 1);
        check("both_full_ordy", 32'(ifa.ordy), 32'd0);
        send_frame(8'h50, 3, 1);
        do_release();
        check("after_rel_ordy", 32'(ifa.ordy), 32'd1);
        check("frame2_len", 32'(ifa.obuf_len), 32'd10);
        do_read(4'd0, 4'd1);
        check("frame2_d0", 32'(ifa.ordat0), 32'h40);
        check("frame2_d1", 32'(ifa.ordat1), 32'h41);
        do_release();
        check("empty_rdy", 32'(ifa.obuf_rdy), 32'd0);

        // Restart with sop inside a frame.
        send_frame(8'h60, 6, 0);
        send_frame(8'h70, 4, 1);
        check("restart_len", 32'(ifa.obuf_len), 32'd4);
        do_read(4'd0, 4'd1);
        check("restart_d0", 32'(ifa.ordat0), 32'h70);
        do_read(4'd3, 4'd2);
        check("restart_d3", 32'(ifa.ordat0), 32'h73);
        check("restart_d2", 32'(ifa.ordat1), 32'h72);
        do_release();

        // Forced close at the last address; the 17th word is dropped.
        send_frame(8'h80, 17, 0);
        check("forced_len", 32'(ifa.obuf_len), 32'd16);
        do_read(4'd15, 4'd14);
        check("forced_d15", 32'(ifa.ordat0), 32'h8F);
        check("forced_d14", 32'(ifa.ordat1), 32'h8E);
        do_release();
        tick();
        check("forced_drop", 32'(ifa.obuf_rdy), 32'd0);

        // Close of B together with release of A.
        send_frame(8'hA0, 3, 1);
        send_frame(8'hB0, 4, 0);
        ival = 1; idat = 8'hB4; ieop = 1; irelease = 1;
        tick();
        ival = 0; ieop = 0; irelease = 0;
        check("simul_rdy", 32'(ifa.obuf_rdy), 32'd1);
        check("simul_len", 32'(ifa.obuf_len), 32'd5);
        check("simul_ordy", 32'(ifa.ordy), 32'd1);
        do_read(4'd4, 4'd3);
        check("simul_d4", 32'(ifa.ordat0), 32'hB4);
        check("simul_d3", 32'(ifa.ordat1), 32'hB3);
        do_release();

        // Clock enable low mid-frame: the held-off word must not land.
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                iclkena = 0; ival = 1; isop = 1; ieop = 1; idat = 8'hEE;
                repeat (3) tick();
                iclkena = 1;
            end
            ival = 1; isop = (i == 0); ieop = (i == 7); idat = 8'hC0 + DW'(i);
            tick();
        end
        ival = 0; isop = 0; ieop = 0;
        check("ena_len", 32'(ifa.obuf_len), 32'd8);
        do_read(4'd3, 4'd2);
        check("ena_d3", 32'(ifa.ordat0), 32'hC3);

        // Clock enable low mid-read: outputs hold.
        do_read(4'd6, 4'd7);
        iclkena = 0; iread = 1; iraddr0 = 4'd0; iraddr1 = 4'd1;
        repeat (3) tick();
        check("hold_orval", 32'(ifa.orval), 32'd1);
        check("hold_d0", 32'(ifa.ordat0), 32'hC6);
        check("hold_d1", 32'(ifa.ordat1), 32'hC7);
        iclkena = 1; iread = 0;
        tick();
        tick();

        // Two-cycle read latency instance.
        do_read(4'd1, 4'd0);
        check("lat1_a", 32'(ifa.orval), 32'd1);
        check("lat2_b_early", 32'(ifb.orval), 32'd0);
        tick();
        check("lat2_b", 32'(ifb.orval), 32'd1);
        check("lat2_b_d0", 32'(ifb.ordat0), 32'hC1);
        check("lat2_b_d1", 32'(ifb.ordat1), 32'hC0);
        do_release();

        // Reset in the middle of a frame with another frame pending.
        send_frame(8'hD0, 4, 1);
        send_frame(8'hE0, 5, 0);
        ireset = 1;
        tick();
        ireset = 0;
        check("midrst_rdy", 32'(ifa.obuf_rdy), 32'd0);
        check("midrst_ordy", 32'(ifa.ordy), 32'd1);
        check("midrst_len", 32'(ifa.obuf_len), 32'd0);
        send_frame(8'hF0, 2, 1);
        check("postrst_len", 32'(ifa.obuf_len), 32'd2);
        do_read(4'd1, 4'd0);
        check("postrst_d1", 32'(ifa.ordat0), 32'hF1);
        check("postrst_d0", 32'(ifa.ordat1), 32'hF0);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
